// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage constants: NOP encoding, reset PC and the BOOT/RUN state encoding.
package if_fetch_stage_pkg;

  localparam logic [31:0] OPC_OP_IMM   = 32'h0000_0013;
  localparam logic [31:0] NOP_INST_DEF = OPC_OP_IMM;  // addi x0,x0,0
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_2000;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_perf_counters.sv
// Fetch performance counters: accepted instructions and killed wrong-path words, wrapping silently.
module fetch_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_inc,
  input  logic             kill_inc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] kill_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       inc;
  logic [CNT_W-1:0] cnt_reg [2];

  assign inc = {kill_inc, fetch_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else if (inc[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_ONE;
        end
      end
    end
  endgenerate

  assign fetch_cnt = cnt_reg[0];
  assign kill_cnt  = cnt_reg[1];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: drives the synchronous imem address, tracks PC/valid of the
// returning word, kills wrong-path words on redirect and counts fetch/kill events.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush_req,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      imem_dout,
  output logic [31:0]      imem_addr,
  output logic [31:0]      inst_id,
  output logic [31:0]      pc_id,
  output logic             valid_id,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] kill_cnt
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_f_reg;
  logic         valid_f_reg;
  logic         in_run;
  logic         fetch_inc;
  logic         kill_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  // pc_f always follows the address just presented, so a stall re-read holds it naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_reg    <= PC_RESET;
      valid_f_reg <= 1'b0;
    end else begin
      pc_f_reg    <= imem_addr;
      valid_f_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = ST_RUN;
    in_run     = (state_reg == ST_RUN);

    imem_addr = next_seq_pc(pc_f_reg);
    if (flush_req) begin
      imem_addr = redirect_pc;
    end else if (!in_run) begin
      imem_addr = PC_RESET;
    end else if (stall) begin
      imem_addr = pc_f_reg;
    end

    valid_id = valid_f_reg & ~flush_req & in_run;
    inst_id  = valid_id ? imem_dout : NOP_INST;
    pc_id    = pc_f_reg;

    fetch_inc = valid_id & ~stall;
    kill_inc  = valid_f_reg & flush_req & in_run;
  end

  fetch_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_inc (fetch_inc),
    .kill_inc  (kill_inc),
    .fetch_cnt (fetch_cnt),
    .kill_cnt  (kill_cnt)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected values queued per cycle, popped on sampling.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush_req;
  logic [31:0] redirect_pc;
  logic [31:0] imem_dout = '0;
  logic [31:0] imem_addr;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        valid_id;
  logic [31:0] fetch_cnt;
  logic [31:0] kill_cnt;

  int checks = 0;
  int errors = 0;

  typedef enum int {S_ADDR, S_PC, S_VALID, S_INST, S_FCNT, S_KCNT} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush_req   (flush_req),
    .redirect_pc (redirect_pc),
    .imem_dout   (imem_dout),
    .imem_addr   (imem_addr),
    .inst_id     (inst_id),
    .pc_id       (pc_id),
    .valid_id    (valid_id),
    .fetch_cnt   (fetch_cnt),
    .kill_cnt    (kill_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous imem model: data is the bitwise inverse of the address read last cycle.
  always @(posedge clk) imem_dout <= ~imem_addr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_ADDR:  return imem_addr;
      S_PC:    return pc_id;
      S_VALID: return {31'd0, valid_id};
      S_INST:  return inst_id;
      S_FCNT:  return fetch_cnt;
      default: return kill_cnt;
    endcase
  endfunction

  task automatic push_exp(input string name, input logic [31:0] e_addr, input logic [31:0] e_pc,
                          input logic e_v, input logic [31:0] e_fc, input logic [31:0] e_kc);
    exp_t e;
    e.tag = {name, ".imem_addr"}; e.sig = S_ADDR;  e.val = e_addr;          sb_q.push_back(e);
    e.tag = {name, ".pc_id"};     e.sig = S_PC;    e.val = e_pc;            sb_q.push_back(e);
    e.tag = {name, ".valid_id"};  e.sig = S_VALID; e.val = {31'd0, e_v};    sb_q.push_back(e);
    e.tag = {name, ".inst_id"};   e.sig = S_INST;  e.val = e_v ? ~e_pc : NOP; sb_q.push_back(e);
    e.tag = {name, ".fetch_cnt"}; e.sig = S_FCNT;  e.val = e_fc;            sb_q.push_back(e);
    e.tag = {name, ".kill_cnt"};  e.sig = S_KCNT;  e.val = e_kc;            sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    exp_t e;
    $display("%-12s addr=%h pc=%h v=%b inst=%h fc=%0d kc=%0d",
             name, imem_addr, pc_id, valid_id, inst_id, fetch_cnt, kill_cnt);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sig), e.val);
    end
  endtask

  // Called at posedge+1: drive inputs, queue expectations, sample at negedge, advance.
  task automatic run_cycle(input string name, input logic s, input logic f, input logic [31:0] rpc,
                           input logic [31:0] e_addr, input logic [31:0] e_pc, input logic e_v,
                           input logic [31:0] e_fc, input logic [31:0] e_kc);
    stall = s; flush_req = f; redirect_pc = rpc;
    push_exp(name, e_addr, e_pc, e_v, e_fc, e_kc);
    @(negedge clk);
    drain(name);
    @(posedge clk); #1;
  endtask

  task automatic reset_check(input string name);
    stall = 1'b0; flush_req = 1'b0; redirect_pc = '0;
    push_exp(name, 32'h2000, 32'h2000, 1'b0, 32'd0, 32'd0);
    #1;
    drain(name);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush_req = 1'b0; redirect_pc = '0;
    @(posedge clk); #1;
    reset_check("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_cycle("boot0",  0, 0, 0, 32'h2000, 32'h2000, 0, 0, 0);
    run_cycle("run1",   0, 0, 0, 32'h2004, 32'h2000, 1, 0, 0);
    run_cycle("run2",   0, 0, 0, 32'h2008, 32'h2004, 1, 1, 0);
    for (int k = 0; k < 3; k++)
      run_cycle($sformatf("stall%0d", k), 1, 0, 0, 32'h2008, 32'h2008, 1, 2, 0);
    run_cycle("unstall",  0, 0, 0, 32'h200C, 32'h2008, 1, 2, 0);
    run_cycle("seq200c",  0, 0, 0, 32'h2010, 32'h200C, 1, 3, 0);
    run_cycle("flush3k",  0, 1, 32'h3000, 32'h3000, 32'h2010, 0, 4, 0);
    run_cycle("flstall4k",1, 1, 32'h4000, 32'h4000, 32'h3000, 0, 4, 1);
    run_cycle("tgt4000",  0, 0, 0, 32'h4004, 32'h4000, 1, 4, 2);
    run_cycle("flush5k",  0, 1, 32'h5000, 32'h5000, 32'h4004, 0, 5, 2);
    run_cycle("flush6k",  0, 1, 32'h6000, 32'h6000, 32'h5000, 0, 5, 3);
    run_cycle("tgt6000",  0, 0, 0, 32'h6004, 32'h6000, 1, 5, 4);
    run_cycle("seq6004",  0, 0, 0, 32'h6008, 32'h6004, 1, 6, 4);

    // Second boot, run up to pc 0x2020, then reset asynchronously mid-cycle.
    rst_n = 1'b0;
    reset_check("reset2");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle("boot0b", 0, 0, 0, 32'h2000, 32'h2000, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      run_cycle($sformatf("runb%0d", k), 0, 0, 0, 32'h2000 + 32'(4 * k),
                32'h2000 + 32'(4 * (k - 1)), 1, 32'(k - 1), 0);
    check_val("pre_reset.pc_id", pc_id, 32'h2020);
    check_val("pre_reset.fetch_cnt", fetch_cnt, 32'd8);
    #2;
    rst_n = 1'b0;
    reset_check("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cycle("boot0c", 0, 0, 0, 32'h2000, 32'h2000, 0, 0, 0);
    run_cycle("runc1",  0, 0, 0, 32'h2004, 32'h2000, 1, 0, 0);
    run_cycle("runc2",  0, 0, 0, 32'h2008, 32'h2004, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
